// File: rtl/ifmap_bank_buf_pkg.sv
// Shared types and defaults for the banked input-feature-map buffer.
package ifmap_bank_buf_pkg;

    localparam int POY_DEF  = 3;
    localparam int ROWS_DEF = 4;
    localparam int COLS_DEF = 64;
    localparam int DW_DEF   = 8;

    localparam logic [1:0] RPSEL_BCAST  = 2'b00;
    localparam logic [1:0] RPSEL_SINGLE = 2'b01;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        READY = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ifmap_bank_buf_if.sv
// Loader write stream, block handshake and read request/response bus.
interface ifmap_bank_buf_if
    import ifmap_bank_buf_pkg::*;
#(
    parameter int POY = POY_DEF,
    parameter int DW  = DW_DEF
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DW-1:0]     wr_data;
    logic              blkend;
    logic              blk_rel;
    logic              rd_en;
    logic [1:0]        rpsel;
    logic [1:0]        bank;
    logic [1:0]        row;
    logic [27:0]       col;
    logic              rd_valid;
    logic [POY*DW-1:0] rd_data;
    logic              rd_err;

    modport master (
        output wr_valid, wr_data, blk_rel, rd_en, rpsel, bank, row, col,
        input  wr_ready, blkend, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  wr_valid, wr_data, blk_rel, rd_en, rpsel, bank, row, col,
        output wr_ready, blkend, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/ifmap_bank_buf_bank.sv
// One ROWS x COLS pixel bank: single write port, registered read port.
module ifbuf_bank
    import ifmap_bank_buf_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int DW   = DW_DEF,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [RW-1:0] wrow,
    input  logic [CW-1:0] wcol,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] rrow,
    input  logic [CW-1:0] rcol,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [ROWS][COLS];

    always_ff @(posedge clk) begin
        if (we)
            mem[wrow][wcol] <= wdata;
        rdata <= mem[rrow][rcol];
    end
endmodule

// File: rtl/ifmap_bank_buf.sv
// Banked ifmap buffer: raster load, 3-stage read pipeline, LOAD/READY/DRAIN control.
// Optional read range checking is enabled with macro IFBUF_RANGE_CHK_EN.
module ifmap_bank_buf
    import ifmap_bank_buf_pkg::*;
#(
    parameter int POY  = POY_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int DW   = DW_DEF
) (
    input logic             clk,
    input logic             rst_n,
    ifmap_bank_buf_if.slave bus
);
    localparam int BW = (POY > 1)  ? $clog2(POY)  : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    state_t state, state_next;

    logic [BW-1:0] wbank;
    logic [RW-1:0] wrow;
    logic [CW-1:0] wcol;
    logic          wr_fire;
    logic          last_px;

    logic          req_err;
    logic          s1_valid, s1_err, s1_single;
    logic [1:0]    s1_bank;
    logic [RW-1:0] s1_row;
    logic [CW-1:0] s1_col;
    logic          s2_valid, s2_err, s2_single;
    logic [1:0]    s2_bank;

    logic [DW-1:0]     bank_rdata [POY];
    logic [POY*DW-1:0] lanes;

    assign wr_fire = bus.wr_valid && (state == LOAD);
    assign last_px = wr_fire && (wrow == RW'(ROWS - 1)) &&
                     (wbank == BW'(POY - 1)) && (wcol == CW'(COLS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= LOAD;
        else
            state <= state_next;
    end

    // DRAIN waits only for accepted reads still in stages 1-2; the output stage finishes on its own.
    always_comb begin
        state_next   = state;
        bus.wr_ready = 1'b0;
        case (state)
            LOAD: begin
                bus.wr_ready = 1'b1;
                if (last_px)
                    state_next = READY;
            end
            READY: if (bus.blk_rel) state_next = DRAIN;
            DRAIN: if (!s1_valid && !s2_valid) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbank      <= '0;
            wrow       <= '0;
            wcol       <= '0;
            bus.blkend <= 1'b0;
        end else begin
            bus.blkend <= last_px;
            if (last_px) begin
                wbank <= '0;
                wrow  <= '0;
                wcol  <= '0;
            end else if (wr_fire) begin
                if (wcol == CW'(COLS - 1)) begin
                    wcol <= '0;
                    if (wbank == BW'(POY - 1)) begin
                        wbank <= '0;
                        wrow  <= wrow + 1'b1;
                    end else begin
                        wbank <= wbank + 1'b1;
                    end
                end else begin
                    wcol <= wcol + 1'b1;
                end
            end
        end
    end

    always_comb begin
        req_err = (state != READY) || bus.rpsel[1];
`ifdef IFBUF_RANGE_CHK_EN
        if ((bus.col >= 28'(COLS)) || (32'(bus.row) >= ROWS) ||
            ((bus.rpsel == RPSEL_SINGLE) && (32'(bus.bank) >= POY)))
            req_err = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
        end else begin
            s1_valid <= bus.rd_en;
            s1_err   <= req_err;
            s2_valid <= s1_valid;
            s2_err   <= s1_err;
        end
        s1_single <= (bus.rpsel == RPSEL_SINGLE);
        s1_bank   <= bus.bank;
        s1_row    <= bus.row[RW-1:0];
        s1_col    <= bus.col[CW-1:0];
        s2_single <= s1_single;
        s2_bank   <= s1_bank;
    end

    for (genvar k = 0; k < POY; k++) begin : g_bank
        ifbuf_bank #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) u_bank (
            .clk   (clk),
            .we    (wr_fire && (wbank == BW'(k))),
            .wrow  (wrow),
            .wcol  (wcol),
            .wdata (bus.wr_data),
            .rrow  (s1_row),
            .rcol  (s1_col),
            .rdata (bank_rdata[k])
        );
    end

    always_comb begin
        lanes = '0;
        if (s2_single) begin
            if (32'(s2_bank) < POY)
                lanes[DW-1:0] = bank_rdata[s2_bank];
        end else begin
            for (int k = 0; k < POY; k++)
                lanes[k*DW +: DW] = bank_rdata[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= s2_valid;
            bus.rd_err   <= s2_valid && s2_err;
            bus.rd_data  <= (s2_valid && !s2_err) ? lanes : '0;
        end
    end
endmodule

// File: tb/tb_ifmap_bank_buf.sv
// Directed bench for ifmap_bank_buf: load, read table, back-to-back, drain and reset cases.
module tb_ifmap_bank_buf;
    import ifmap_bank_buf_pkg::*;

    localparam int POY  = 3;
    localparam int ROWS = 4;
    localparam int COLS = 64;
    localparam int DW   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifmap_bank_buf_if #(.POY(POY), .DW(DW)) bus ();

    ifmap_bank_buf #(.POY(POY), .ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  rpsel;
        logic [1:0]  bank;
        logic [1:0]  row;
        logic [27:0] col;
        logic        exp_err;
        logic [23:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses;
    int   pulse_at;
    logic ready_ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResp(input string name, input logic exp_err, input logic [23:0] exp_data);
        checkOutput({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
        checkOutput({name, "_err"},   32'(bus.rd_err),   32'(exp_err));
        checkOutput({name, "_data"},  32'(bus.rd_data),  32'(exp_data));
    endtask

    // Drives one read request for a single cycle; returns in the following cycle.
    task automatic applyStimulus(input logic [1:0] rpsel, input logic [1:0] bank,
                                 input logic [1:0] row, input logic [27:0] col);
        bus.rd_en = 1'b1;
        bus.rpsel = rpsel;
        bus.bank  = bank;
        bus.row   = row;
        bus.col   = col;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic writePixels(input int n);
        pulses   = 0;
        pulse_at = -1;
        ready_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (!bus.wr_ready) ready_ok = 1'b0;
            bus.wr_valid = 1'b1;
            bus.wr_data  = i[7:0];
            tick();
            if (bus.blkend) begin
                pulses++;
                pulse_at = i;
            end
        end
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.blk_rel  = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rpsel    = '0;
        bus.bank     = '0;
        bus.row      = '0;
        bus.col      = '0;

        // Pixel at raster index i holds i mod 256, index = row*192 + bank*64 + col.
        vecs.push_back('{RPSEL_BCAST,  2'd0, 2'd1, 28'd5,  1'b0, {8'd69,  8'd5,   8'd197}});
        vecs.push_back('{RPSEL_SINGLE, 2'd0, 2'd0, 28'd0,  1'b0, 24'd0});
        vecs.push_back('{RPSEL_SINGLE, 2'd2, 2'd3, 28'd63, 1'b0, 24'd255});
        vecs.push_back('{RPSEL_SINGLE, 2'd1, 2'd2, 28'd10, 1'b0, 24'd202});
        vecs.push_back('{RPSEL_BCAST,  2'd0, 2'd3, 28'd63, 1'b0, {8'd255, 8'd191, 8'd127}});
        vecs.push_back('{RPSEL_BCAST,  2'd3, 2'd0, 28'd0,  1'b0, {8'd128, 8'd64,  8'd0}});
        vecs.push_back('{2'b10,        2'd1, 2'd1, 28'd1,  1'b1, 24'd0});
        vecs.push_back('{2'b11,        2'd0, 2'd0, 28'd2,  1'b1, 24'd0});
`ifdef IFBUF_RANGE_CHK_EN
        vecs.push_back('{RPSEL_SINGLE, 2'd1, 2'd1, 28'd64, 1'b1, 24'd0});
        vecs.push_back('{RPSEL_SINGLE, 2'd3, 2'd0, 28'd0,  1'b1, 24'd0});
`else
        vecs.push_back('{RPSEL_SINGLE, 2'd1, 2'd1, 28'd71, 1'b0, 24'd7});
`endif

        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        checkOutput("rst_blkend",   32'(bus.blkend),   32'd0);
        checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("rst_rd_err",   32'(bus.rd_err),   32'd0);
        checkOutput("rst_rd_data",  32'(bus.rd_data),  32'd0);
        rst_n = 1'b1;
        tick();

        applyStimulus(RPSEL_BCAST, 2'd0, 2'd0, 28'd0);
        tick();
        checkOutput("load_rd_lat2", 32'(bus.rd_valid), 32'd0);
        tick();
        checkResp("load_rd", 1'b1, 24'd0);

        // Partial load aborted by reset must not count toward the block.
        writePixels(300);
        checkOutput("partial_no_blkend", 32'(pulses), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        writePixels(768);
        checkOutput("load_wr_ready",   32'(ready_ok), 32'd1);
        checkOutput("blkend_count",    32'(pulses),   32'd1);
        checkOutput("blkend_position", 32'(pulse_at), 32'd767);
        tick();
        checkOutput("blkend_one_cycle", 32'(bus.blkend),   32'd0);
        checkOutput("ready_wr_ready",   32'(bus.wr_ready), 32'd0);

        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hFF;
        tick();
        tick();
        bus.wr_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rpsel, vecs[i].bank, vecs[i].row, vecs[i].col);
            checkOutput($sformatf("vec%0d_lat1", i), 32'(bus.rd_valid), 32'd0);
            tick();
            checkOutput($sformatf("vec%0d_lat2", i), 32'(bus.rd_valid), 32'd0);
            tick();
            checkResp($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_data);
        end

        bus.rd_en = 1'b1;
        bus.rpsel = RPSEL_SINGLE;
        bus.row   = 2'd0;
        bus.col   = 28'd0;
        bus.bank  = 2'd0;
        tick();
        bus.bank  = 2'd1;
        tick();
        bus.bank  = 2'd2;
        tick();
        bus.rd_en = 1'b0;
        checkResp("b2b0", 1'b0, 24'd0);
        tick();
        checkResp("b2b1", 1'b0, 24'd64);
        tick();
        checkResp("b2b2", 1'b0, 24'd128);
        tick();
        checkOutput("b2b_idle", 32'(bus.rd_valid), 32'd0);

        // Release the block with two reads in flight.
        bus.rd_en = 1'b1;
        bus.rpsel = RPSEL_SINGLE;
        bus.bank  = 2'd1;
        bus.row   = 2'd0;
        bus.col   = 28'd1;
        tick();
        bus.rpsel   = RPSEL_BCAST;
        bus.row     = 2'd2;
        bus.col     = 28'd3;
        bus.blk_rel = 1'b1;
        tick();
        bus.rd_en   = 1'b0;
        bus.blk_rel = 1'b0;
        checkOutput("drain_wr_ready_a", 32'(bus.wr_ready), 32'd0);
        tick();
        checkResp("drain0", 1'b0, 24'd65);
        tick();
        checkResp("drain1", 1'b0, {8'd3, 8'd195, 8'd131});
        checkOutput("drain_wr_ready_b", 32'(bus.wr_ready), 32'd0);
        tick();
        for (int i = 0; i < 5 && !bus.wr_ready; i++) tick();
        checkOutput("drain_to_load", 32'(bus.wr_ready), 32'd1);

        applyStimulus(RPSEL_BCAST, 2'd0, 2'd0, 28'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rst_flush_a", 32'(bus.rd_valid), 32'd0);
        tick();
        checkOutput("rst_flush_b", 32'(bus.rd_valid), 32'd0);
        tick();
        checkOutput("rst_flush_c", 32'(bus.rd_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
